pc_offset_adder: RTL
====================

PC_OFFSET_ADDER -- requirements
Module: pc_offset_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 16, giving the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK, with N = WIDTH/CHUNK.
REQ-003 The block SHALL have parameter SHIFT, default 2, giving the left shift applied to the offset when shift mode is enabled.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port i_clk SHALL be an input, 1 bit wide: the clock; all state updates on its rising edge.
REQ-006 Port i_rst_n SHALL be an input, 1 bit wide: the asynchronous active-low reset.
REQ-007 Port i_start SHALL be an input, 1 bit wide: a request to begin an operation, sampled only in IDLE.
REQ-008 Port i_a SHALL be an input, WIDTH bits wide: the base operand (PC), unsigned.
REQ-009 Port i_b SHALL be an input, WIDTH bits wide: the offset, signed two's complement.
REQ-010 Port i_sub SHALL be an input, 1 bit wide: 0 computes a+b_eff, 1 computes a-b_eff.
REQ-011 Port i_shift_en SHALL be an input, 1 bit wide: 1 sets b_eff = i_b <<< SHIFT, 0 sets b_eff = i_b.
REQ-012 Port o_busy SHALL be an output, 1 bit wide: high while an operation is in progress.
REQ-013 Port o_done SHALL be an output, 1 bit wide: a one-cycle pulse when the result becomes valid.
REQ-014 Port o_res SHALL be an output, WIDTH bits wide: the result of the last completed operation.
REQ-015 Port o_carry SHALL be an output, 1 bit wide: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-016 Port o_ovf SHALL be an output, 1 bit wide: signed overflow of the last completed operation.

Function
REQ-017 The FSM SHALL have two states: IDLE and CALC.
REQ-018 In IDLE with i_start=1 at an edge, the block SHALL latch i_a, b_eff (inverted if i_sub=1), and a carry-in of i_sub, clear the slice counter, go to CALC, and set o_busy=1.
REQ-019 i_a, i_b, i_sub, and i_shift_en SHALL be sampled only at the accepting edge; later input changes SHALL have no effect on the operation in flight.
REQ-020 In CALC, each edge SHALL add slice k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of both latched operands plus the stored carry, write the sum into slice k of an internal accumulator, store the carry-out, and increment k.
REQ-021 At the edge processing slice N-1, the block SHALL copy the accumulator to o_res, set o_carry to the final carry, set o_ovf to the carry into the MSB XOR the carry out of the MSB, pulse o_done=1 for one cycle, clear o_busy, and return to IDLE.
REQ-022 Latency: if the start is accepted at edge t, o_done SHALL be high in the cycle following edge t+N; throughput SHALL be one operation per N+1 cycles at most.
REQ-023 i_start while o_busy=1, including the cycle of the last-slice edge, SHALL be ignored; no queueing SHALL occur.
REQ-024 i_start in the cycle where o_done=1 SHALL be accepted, since the FSM is already in IDLE.
REQ-025 o_res, o_carry, and o_ovf SHALL hold their values until the next completion; partial sums SHALL never appear on o_res.
REQ-026 Bits shifted out above the MSB by SHIFT SHALL be discarded; the shift SHALL be arithmetic with respect to the sign of i_b.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH.
REQ-028 When N=1, the operation SHALL complete at the first CALC edge.

Reset
REQ-029 While i_rst_n=0, the block SHALL force state=IDLE, slice counter=0, o_busy=0, o_done=0, o_res=0, o_carry=0, o_ovf=0, and clear the latched operands and carry, independent of i_clk.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no o_done pulse; the first i_start after deassertion SHALL be processed normally.

Verification
REQ-031 Test WIDTH=64, CHUNK=16: i_a=0x1000, i_b=0x10, i_shift_en=1, i_sub=0 -> o_res=0x1040, o_carry=0, o_ovf=0, and o_done exactly 4 cycles after the accepting edge.
REQ-032 Test i_a=0x1000, i_b=0xFFFF_FFFF_FFFF_FFFC (-4), i_shift_en=1 -> o_res=0x0FF0, o_carry=1, o_ovf=0.
REQ-033 Test i_a=0x7FFF_FFFF_FFFF_FFFF, i_b=1, i_shift_en=0 -> o_res=0x8000_0000_0000_0000, o_ovf=1, o_carry=0.
REQ-034 Test i_sub=1, i_a=5, i_b=7 -> o_res=0xFFFF_FFFF_FFFF_FFFE, o_carry=0, o_ovf=0; and i_a=0xFFFF, i_b=1, add -> o_res=0x10000, which exercises the carry across slices.
REQ-035 Test a second i_start while busy, with different operands -> the first result is unchanged and only one o_done pulse occurs; then assert i_rst_n=0 at cycle 2 of a new operation -> all outputs are 0 and no o_done occurs, and a following start completes correctly.
REQ-036 Test WIDTH=32, CHUNK=8: i_a=0x0000_00FF, i_b=0x0000_0001 -> o_res=0x0000_0100 with o_done 4 cycles after the start.

Source files
------------

// File: rtl/pc_offset_adder.sv
// Multi-cycle PC + offset adder: adds CHUNK bits per clock over N = WIDTH/CHUNK cycles.
// Supports subtract (a - b_eff) and an optional arithmetic left shift of the offset.
module pc_offset_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int SHIFT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_shift_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_ovf
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0][CHUNK-1:0] r_a;
  logic [N-1:0][CHUNK-1:0] r_b;
  logic [N-1:0][CHUNK-1:0] r_acc;
  logic [N-1:0][CHUNK-1:0] w_acc_next;
  logic                    r_carry;
  logic [CNT_W-1:0]        r_cnt;

  logic [WIDTH-1:0] r_res;
  logic             r_carry_out;
  logic             r_ovf;
  logic             r_done;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_b_lat;
  logic [CHUNK:0]   w_sum;
  logic             w_accept;
  logic             w_last;
  logic             w_msb_cin;
  logic             w_ovf;

  // A left shift is identical for signed and unsigned operands; bits above the MSB fall off.
  assign w_b_eff  = i_shift_en ? (i_b << SHIFT) : i_b;
  assign w_b_lat  = i_sub ? ~w_b_eff : w_b_eff;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_CALC) && (r_cnt == LAST_SLICE);

  assign w_sum = {1'b0, r_a[r_cnt]} + {1'b0, r_b[r_cnt]} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the top bit is recovered from that bit's sum and its two operand bits.
  assign w_msb_cin = w_sum[CHUNK-1] ^ r_a[r_cnt][CHUNK-1] ^ r_b[r_cnt][CHUNK-1];
  assign w_ovf     = w_msb_cin ^ w_sum[CHUNK];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_acc_next        = r_acc;
    w_acc_next[r_cnt] = w_sum[CHUNK-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_SLICE) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: operand and accumulator registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= w_b_lat;
        r_carry <= i_sub;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_CALC) begin
        r_acc   <= w_acc_next;
        r_carry <= w_sum[CHUNK];
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_res       <= w_acc_next;
          r_carry_out <= w_sum[CHUNK];
          r_ovf       <= w_ovf;
          r_done      <= 1'b1;
        end
      end
    end
  end

  assign o_busy  = (r_state == S_CALC);
  assign o_done  = r_done;
  assign o_res   = r_res;
  assign o_carry = r_carry_out;
  assign o_ovf   = r_ovf;

endmodule
